// File: rtl/valid_ready_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready requesters into one registered
// downstream beat, with a sticky flag for a downstream that stops accepting.
module valid_ready_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int STALL_MAX = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          in_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   in_data,
    output logic [NUM_REQ-1:0]          in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(NUM_REQ)-1:0]  out_id,
    input  logic                        out_ready,
    output logic                        stall_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STALL_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   rr_next;
    logic              found;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  stall_inc;

    // Scan from rr_ptr upward, wrapping, and keep the first valid requester.
    always_comb begin : winner_sel
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign rr_next   = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
    assign stall_inc = (stall_cnt == CNT_W'(STALL_MAX)) ? stall_cnt : stall_cnt + CNT_W'(1);

    assign in_ready  = (rst_n && (state == IDLE) && found) ? (NUM_REQ'(1) << winner) : '0;

    // A beat stays in the output register until downstream takes it; only reset drops it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BUSY;
                        out_valid <= 1'b1;
                        out_data  <= in_data[int'(winner)*DATA_W +: DATA_W];
                        out_id    <= winner;
                        rr_ptr    <= rr_next;
                        stall_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else begin
                        stall_cnt <= stall_inc;
                        if (stall_inc == CNT_W'(STALL_MAX)) begin
                            stall_err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
